// File: rtl/quadrature_step_decoder.sv
// quadrature_step_decoder
//   Turns a two-phase quadrature input into a one-cycle step pulse plus a
//   level direction for a downstream up/down counter. The pins are
//   synchronised, optionally glitch-filtered, and Gray-code decoded.
//   Illegal double-bit transitions are reported.
//
//   Build option: define QUAD_GLITCH_FILTER_EN to include the glitch filter.
//   Without it, the synchronised value feeds the decoder directly and
//   FILTER_CYCLES has no effect.
//
// Parameters
//   FILTER_CYCLES : number of consecutive clocks (1..15) a new A/B value
//                   must hold before it is accepted.
// Ports
//   clock     : sole clock; all state updates on the rising edge
//   reset     : synchronous, active-high
//   quad_a    : phase A, asynchronous to clock
//   quad_b    : phase B, asynchronous to clock
//   decode_en : 1 = report steps and errors; 0 = step/err_pulse held low
//   err_clear : clears the sticky err_flag (a coincident error wins)
//   step      : one-cycle pulse per accepted legal transition
//   direction : 1 = up, 0 = down; holds the last decoded direction
//   err_pulse : one-cycle pulse on an illegal (double-bit) transition
//   err_flag  : sticky error indicator
module quadrature_step_decoder #(
   parameter int unsigned FILTER_CYCLES = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic quad_a,
   input  logic quad_b,
   input  logic decode_en,
   input  logic err_clear,
   output logic step,
   output logic direction,
   output logic err_pulse,
   output logic err_flag
);

   logic [1:0] r_sync1;
   logic [1:0] r_sync2;
   logic [1:0] w_sync_ab;
   logic [1:0] w_filt_ab;
   logic [1:0] r_prev_ab;
   logic [1:0] w_delta;
   logic       w_single;
   logic       w_double;
   logic       w_up;
   logic       r_step;
   logic       r_dir;
   logic       r_err_pulse;
   logic       r_err_flag;

   // Two-flop synchroniser per phase.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {quad_a, quad_b};
         r_sync2 <= r_sync1;
      end
   end

   assign w_sync_ab = r_sync2;

`ifdef QUAD_GLITCH_FILTER_EN
   localparam logic [3:0] LP_FILTER = FILTER_CYCLES[3:0];

   logic [1:0] r_filt_ab;
   logic [1:0] r_sync_last;
   logic [3:0] r_stab_cnt;
   logic [3:0] w_stab_next;
   logic       w_accept;

   // The count includes the current edge: the first edge that sees a new
   // value counts 1, so acceptance happens on the FILTER_CYCLES-th edge.
   always_comb begin
      w_stab_next = '0;
      if (w_sync_ab != r_filt_ab) begin
         if (w_sync_ab == r_sync_last)
            w_stab_next = r_stab_cnt + 4'd1;
         else
            w_stab_next = 4'd1;
      end
   end

   assign w_accept = (w_stab_next == LP_FILTER);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_filt_ab   <= '0;
         r_sync_last <= '0;
         r_stab_cnt  <= '0;
      end else begin
         r_sync_last <= w_sync_ab;
         if (w_accept) begin
            r_filt_ab  <= w_sync_ab;
            r_stab_cnt <= '0;
         end else begin
            r_stab_cnt <= w_stab_next;
         end
      end
   end

   assign w_filt_ab = r_filt_ab;
`else
   assign w_filt_ab = w_sync_ab;
`endif

   // Gray decode: exactly one changed bit is a step, both is illegal.
   // For a single-bit change, up (00->01->11->10->00) is prev[1] ^ new[0].
   assign w_delta  = w_filt_ab ^ r_prev_ab;
   assign w_single = ^w_delta;
   assign w_double = &w_delta;
   assign w_up     = r_prev_ab[1] ^ w_filt_ab[0];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_prev_ab   <= '0;
         r_step      <= 1'b0;
         r_dir       <= 1'b1;
         r_err_pulse <= 1'b0;
         r_err_flag  <= 1'b0;
      end else begin
         r_prev_ab   <= w_filt_ab;
         r_step      <= decode_en & w_single;
         r_err_pulse <= decode_en & w_double;
         if (w_single)
            r_dir <= w_up;
         if (w_double)
            r_err_flag <= 1'b1;
         else if (err_clear)
            r_err_flag <= 1'b0;
      end
   end

   assign step      = r_step;
   assign direction = r_dir;
   assign err_pulse = r_err_pulse;
   assign err_flag  = r_err_flag;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
module tb_quadrature_step_decoder;

   localparam int unsigned F = 4;
`ifdef QUAD_GLITCH_FILTER_EN
   localparam int unsigned LAT = F + 2;
   localparam int GLITCH_STEPS = 0;
`else
   localparam int unsigned LAT = 2;
   localparam int GLITCH_STEPS = 2;
`endif

   logic clock = 1'b0;
   logic reset;
   logic quad_a;
   logic quad_b;
   logic decode_en;
   logic err_clear;
   logic step;
   logic direction;
   logic err_pulse;
   logic err_flag;

   int n_cmp = 0;
   int n_bad = 0;
   int step_cnt = 0;
   int err_cnt = 0;
   logic [2:0] ctr = 3'd0;
   logic prev_step = 1'b0;

   typedef struct {
      logic [1:0] ab;
      logic       en;
      int         steps;
      int         errs;
      logic       dir;
      logic       flag;
      logic [2:0] ctr;
   } vec_t;

   vec_t vecs[17];

   quadrature_step_decoder #(.FILTER_CYCLES(F)) dut (
      .clock     (clock),
      .reset     (reset),
      .quad_a    (quad_a),
      .quad_b    (quad_b),
      .decode_en (decode_en),
      .err_clear (err_clear),
      .step      (step),
      .direction (direction),
      .err_pulse (err_pulse),
      .err_flag  (err_flag)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Downstream 3-bit counter and pulse tallies, sampled at the active edge.
   always @(posedge clock) begin
      if (reset)
         ctr <= 3'd0;
      else if (step)
         ctr <= direction ? ctr + 3'd1 : ctr - 3'd1;
      step_cnt <= step_cnt + int'(step);
      err_cnt  <= err_cnt + int'(err_pulse);
   end

   always @(negedge clock) begin
      if (!reset) begin
         if (step && err_pulse)
            check("step_err_exclusive", 1, 0);
         if (step && prev_step)
            check("step_back_to_back", 1, 0);
      end
      prev_step <= step;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_ab(input logic [1:0] ab);
      quad_a = ab[1];
      quad_b = ab[0];
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      set_ab(2'b00);
      cyc(2);
      reset = 1'b0;
      cyc(1);
   endtask

   initial begin
      int s0;
      int e0;
      int lat;
      reset = 1'b1;
      quad_a = 1'b1;
      quad_b = 1'b1;
      decode_en = 1'b1;
      err_clear = 1'b0;

      vecs[0]  = '{2'b10, 1'b1, 1, 0, 1'b0, 1'b0, 3'd7};
      vecs[1]  = '{2'b11, 1'b1, 1, 0, 1'b0, 1'b0, 3'd6};
      vecs[2]  = '{2'b10, 1'b1, 1, 0, 1'b1, 1'b0, 3'd7};
      vecs[3]  = '{2'b00, 1'b1, 1, 0, 1'b1, 1'b0, 3'd0};
      vecs[4]  = '{2'b01, 1'b1, 1, 0, 1'b1, 1'b0, 3'd1};
      vecs[5]  = '{2'b11, 1'b1, 1, 0, 1'b1, 1'b0, 3'd2};
      vecs[6]  = '{2'b10, 1'b1, 1, 0, 1'b1, 1'b0, 3'd3};
      vecs[7]  = '{2'b00, 1'b1, 1, 0, 1'b1, 1'b0, 3'd4};
      vecs[8]  = '{2'b10, 1'b1, 1, 0, 1'b0, 1'b0, 3'd3};
      vecs[9]  = '{2'b00, 1'b0, 0, 0, 1'b1, 1'b0, 3'd3};
      vecs[10] = '{2'b01, 1'b0, 0, 0, 1'b1, 1'b0, 3'd3};
      vecs[11] = '{2'b11, 1'b1, 1, 0, 1'b1, 1'b0, 3'd4};
      vecs[12] = '{2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 3'd4};
      vecs[13] = '{2'b00, 1'b1, 1, 0, 1'b0, 1'b0, 3'd3};
      vecs[14] = '{2'b11, 1'b1, 0, 1, 1'b0, 1'b1, 3'd3};
      vecs[15] = '{2'b00, 1'b0, 0, 0, 1'b0, 1'b1, 3'd3};
      vecs[16] = '{2'b01, 1'b1, 1, 0, 1'b1, 1'b1, 3'd4};

      // Reset with arbitrary pins held high.
      cyc(3);
      check("rst_step", int'(step), 0);
      check("rst_dir", int'(direction), 1);
      check("rst_err_flag", int'(err_flag), 0);
      check("rst_err_pulse", int'(err_pulse), 0);
      set_ab(2'b00);
      reset = 1'b0;
      cyc(1);
      check("post_rst_step", int'(step), 0);
      cyc(LAT + 2);
      check("post_rst_quiet", step_cnt + err_cnt, 0);

      // Latency of a single legal transition.
      set_ab(2'b01);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clock);
         if (step) begin
            lat = i;
            break;
         end
      end
      check("latency", lat, int'(LAT) + 1);
      cyc(1);
      check("step_one_cycle", int'(step), 0);

      // Reset mid-transition discards the pending change.
      do_reset();
      s0 = step_cnt;
      set_ab(2'b01);
      cyc(2);
      reset = 1'b1;
      set_ab(2'b00);
      cyc(1);
      reset = 1'b0;
      cyc(12);
      check("midrst_steps", step_cnt - s0, 0);
      check("midrst_dir", int'(direction), 1);

      // Table-driven sweeps, reversal, decode_en and illegal jumps.
      do_reset();
      foreach (vecs[k]) begin
         s0 = step_cnt;
         e0 = err_cnt;
         set_ab(vecs[k].ab);
         decode_en = vecs[k].en;
         cyc(10);
         check($sformatf("v%0d_steps", k), step_cnt - s0, vecs[k].steps);
         check($sformatf("v%0d_errs", k), err_cnt - e0, vecs[k].errs);
         check($sformatf("v%0d_dir", k), int'(direction), int'(vecs[k].dir));
         check($sformatf("v%0d_flag", k), int'(err_flag), int'(vecs[k].flag));
         check($sformatf("v%0d_ctr", k), int'(ctr), int'(vecs[k].ctr));
      end
      decode_en = 1'b1;

      // Glitch: A high for F-1 clocks, then exactly F clocks.
      do_reset();
      s0 = step_cnt;
      set_ab(2'b10);
      cyc(F - 1);
      set_ab(2'b00);
      cyc(12);
      check("glitch_steps", step_cnt - s0, GLITCH_STEPS);
      check("glitch_dir", int'(direction), 1);
      s0 = step_cnt;
      set_ab(2'b10);
      cyc(F);
      set_ab(2'b00);
      cyc(14);
      check("hold_f_steps", step_cnt - s0, 2);
      check("hold_f_ctr", int'(ctr), 0);

      // Illegal jump, then clear coinciding with a second error, then clear alone.
      do_reset();
      s0 = step_cnt;
      e0 = err_cnt;
      set_ab(2'b11);
      cyc(10);
      check("ill_errs", err_cnt - e0, 1);
      check("ill_steps", step_cnt - s0, 0);
      check("ill_flag", int'(err_flag), 1);
      set_ab(2'b00);
      cyc(LAT);
      err_clear = 1'b1;
      cyc(1);
      err_clear = 1'b0;
      check("ill2_pulse", int'(err_pulse), 1);
      check("ill2_flag_set_wins", int'(err_flag), 1);
      cyc(3);
      err_clear = 1'b1;
      cyc(1);
      err_clear = 1'b0;
      check("clear_flag", int'(err_flag), 0);
      check("ill_total_errs", err_cnt - e0, 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
